// File: rtl/io_pkg.sv
// Shared constants and helpers for the memory-stage I/O port controller.
package io_pkg;

  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_UNF   = 1;
  localparam int unsigned ERR_SEL   = 2;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Input-side word FIFO; state changes on the falling clock edge like the rest of the I/O block.
module io_fifo
  import io_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-stage I/O controller: buffered input FIFO with empty-read bypass,
// N independently addressed output lanes with update strobes, sticky error flags.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned SEL_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           Result,
  input  logic [SEL_W-1:0]           PORT_SEL,
  input  logic                       IOE,
  input  logic                       IOR,
  input  logic                       IOW,
  input  logic [WIDTH-1:0]           PORTIN,
  input  logic                       PORTIN_VALID,
  output logic                       PORTIN_READY,
  output logic [WIDTH-1:0]           IN,
  output logic                       IN_VALID,
  output logic [N_PORTS*WIDTH-1:0]   PORTOUT,
  output logic [N_PORTS-1:0]         PORTOUT_STB,
  output logic [clog2(DEPTH):0]      FIFO_COUNT,
  input  logic                       CLR_FLAGS,
  output logic [2:0]                 ERR_FLAGS
);

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             rd_req;
  logic             wr_req;
  logic             bypass;
  logic             sel_ok;
  logic             ovf;
  logic             unf;
  logic             bad_sel;
  logic [2:0]       err_next;

  assign rd_req  = IOE & IOR;
  assign wr_req  = IOE & IOW;
  // An empty read with a word arriving on the same edge takes it straight to IN.
  assign bypass  = rd_req & fifo_empty & PORTIN_VALID;
  assign fifo_push = PORTIN_VALID & ~bypass;
  assign ovf     = PORTIN_VALID & fifo_full;
  assign unf     = rd_req & fifo_empty & ~PORTIN_VALID;
  assign sel_ok  = (32'(PORT_SEL) < N_PORTS);
  assign bad_sel = wr_req & ~sel_ok;

  assign PORTIN_READY = ~fifo_full;

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (rd_req),
    .din   (PORTIN),
    .dout  (fifo_dout),
    .count (FIFO_COUNT),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      IN       <= '0;
      IN_VALID <= 1'b0;
    end else if (rd_req && !fifo_empty) begin
      IN       <= fifo_dout;
      IN_VALID <= 1'b1;
    end else if (bypass) begin
      IN       <= PORTIN;
      IN_VALID <= 1'b1;
    end else begin
      IN_VALID <= 1'b0;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      PORTOUT     <= '0;
      PORTOUT_STB <= '0;
    end else begin
      PORTOUT_STB <= '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
        if (wr_req && sel_ok && (32'(PORT_SEL) == k)) begin
          PORTOUT[k*WIDTH +: WIDTH] <= Result;
          PORTOUT_STB[k]            <= 1'b1;
        end
      end
    end
  end

  // Clear first, then OR in this edge's errors so a coincident error survives the clear.
  always_comb begin
    err_next          = CLR_FLAGS ? 3'b000 : ERR_FLAGS;
    err_next[ERR_OVF] = err_next[ERR_OVF] | ovf;
    err_next[ERR_UNF] = err_next[ERR_UNF] | unf;
    err_next[ERR_SEL] = err_next[ERR_SEL] | bad_sel;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) ERR_FLAGS <= '0;
    else        ERR_FLAGS <= err_next;
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_io_port_ctrl;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int NP = 3;
  localparam int SW = 2;

  logic          clk = 1'b1;
  logic          reset = 1'b0;
  logic [W-1:0]  Result;
  logic [SW-1:0] PORT_SEL;
  logic          IOE, IOR, IOW;
  logic [W-1:0]  PORTIN;
  logic          PORTIN_VALID;
  logic          PORTIN_READY;
  logic [W-1:0]  IN;
  logic          IN_VALID;
  logic [NP*W-1:0] PORTOUT;
  logic [NP-1:0] PORTOUT_STB;
  logic [2:0]    FIFO_COUNT;
  logic          CLR_FLAGS;
  logic [2:0]    ERR_FLAGS;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]  mq [$];
  logic [W-1:0]  m_in;
  logic          m_inv;
  logic [W-1:0]  m_lane [NP];
  logic [NP-1:0] m_stb;
  logic [2:0]    m_flags;

  io_port_ctrl #(
    .WIDTH   (W),
    .DEPTH   (D),
    .N_PORTS (NP),
    .SEL_W   (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Result       (Result),
    .PORT_SEL     (PORT_SEL),
    .IOE          (IOE),
    .IOR          (IOR),
    .IOW          (IOW),
    .PORTIN       (PORTIN),
    .PORTIN_VALID (PORTIN_VALID),
    .PORTIN_READY (PORTIN_READY),
    .IN           (IN),
    .IN_VALID     (IN_VALID),
    .PORTOUT      (PORTOUT),
    .PORTOUT_STB  (PORTOUT_STB),
    .FIFO_COUNT   (FIFO_COUNT),
    .CLR_FLAGS    (CLR_FLAGS),
    .ERR_FLAGS    (ERR_FLAGS)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    Result = '0; PORT_SEL = '0; IOE = 0; IOR = 0; IOW = 0;
    PORTIN = '0; PORTIN_VALID = 0; CLR_FLAGS = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_in = '0; m_inv = 0; m_stb = '0; m_flags = '0;
    for (int i = 0; i < NP; i++) m_lane[i] = '0;
  endtask

  // Applies the block's rules for one falling edge given the inputs currently driven.
  task automatic model_edge();
    int   cnt0 = mq.size();
    bit   rd   = IOE && IOR;
    bit   wr   = IOE && IOW;
    bit   byp  = 0;
    logic [2:0] e = '0;
    m_inv = 0;
    m_stb = '0;
    if (rd) begin
      if (cnt0 > 0) begin m_in = mq.pop_front(); m_inv = 1; end
      else if (PORTIN_VALID) begin m_in = PORTIN; m_inv = 1; byp = 1; end
      else e[1] = 1;
    end
    if (PORTIN_VALID && !byp) begin
      if (cnt0 < D) mq.push_back(PORTIN);
      else e[0] = 1;
    end
    if (wr) begin
      if (PORT_SEL < NP) begin m_lane[PORT_SEL] = Result; m_stb[PORT_SEL] = 1; end
      else e[2] = 1;
    end
    if (CLR_FLAGS) m_flags = '0;
    m_flags = m_flags | e;
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    drive_idle(); PORTIN = w; PORTIN_VALID = 1; step();
  endtask

  task automatic read_word();
    drive_idle(); IOE = 1; IOR = 1; step();
  endtask

  task automatic clear_flags();
    drive_idle(); CLR_FLAGS = 1; step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) push_word(16'h0101 + 16'(i));
    drive_idle(); IOE = 1; IOW = 1; PORT_SEL = 2'd3; Result = 16'hDEAD; step();
    drive_idle(); IOE = 1; IOR = 1; IOW = 1; PORT_SEL = 2'd0; Result = 16'h1234; step();
    vectors++; if (FIFO_COUNT !== 3'd3 || IN !== 16'h0101 || IN_VALID !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_state: count=%0d IN=%h v=%b want 3 0101 1", FIFO_COUNT, IN, IN_VALID); end
    vectors++; if (ERR_FLAGS !== 3'b100 || PORTOUT_STB !== 3'b001) begin
      miscompares++; $display("FAIL pre_reset_flags: err=%b stb=%b want 100 001", ERR_FLAGS, PORTOUT_STB); end
    #2 reset = 0;
    #1;
    vectors++; if (FIFO_COUNT !== 3'd0 || IN !== '0 || IN_VALID !== 1'b0 || PORTIN_READY !== 1'b1) begin
      miscompares++; $display("FAIL reset_fifo_in: count=%0d IN=%h v=%b rdy=%b want 0 0000 0 1", FIFO_COUNT, IN, IN_VALID, PORTIN_READY); end
    vectors++; if (PORTOUT !== '0 || PORTOUT_STB !== '0 || ERR_FLAGS !== '0) begin
      miscompares++; $display("FAIL reset_out_flags: out=%h stb=%b err=%b want 0 0 0", PORTOUT, PORTOUT_STB, ERR_FLAGS); end
    #1 reset = 1;
    model_reset();
    push_word(16'h1111);
    push_word(16'h2222);
    vectors++; if (FIFO_COUNT !== 3'd2) begin
      miscompares++; $display("FAIL post_reset_count: got %0d want 2", FIFO_COUNT); end
    read_word();
    vectors++; if (IN !== 16'h1111 || IN_VALID !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_read1: IN=%h v=%b want 1111 1", IN, IN_VALID); end
    read_word();
    vectors++; if (IN !== 16'h2222 || FIFO_COUNT !== 3'd0) begin
      miscompares++; $display("FAIL post_reset_read2: IN=%h count=%0d want 2222 0", IN, FIFO_COUNT); end
  endtask

  task automatic test_fifo_wrap();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) push_word(16'hA001 + 16'(i));
      vectors++; if (FIFO_COUNT !== 3'd4 || PORTIN_READY !== 1'b0) begin
        miscompares++; $display("FAIL wrap_full rep%0d: count=%0d rdy=%b want 4 0", rep, FIFO_COUNT, PORTIN_READY); end
      push_word(16'hA005);
      vectors++; if (ERR_FLAGS !== 3'b001 || FIFO_COUNT !== 3'd4) begin
        miscompares++; $display("FAIL wrap_overflow rep%0d: err=%b count=%0d want 001 4", rep, ERR_FLAGS, FIFO_COUNT); end
      for (int i = 0; i < 4; i++) begin
        read_word();
        vectors++; if (IN !== 16'hA001 + 16'(i) || IN_VALID !== 1'b1) begin
          miscompares++; $display("FAIL wrap_order rep%0d i%0d: IN=%h v=%b want %h 1", rep, i, IN, IN_VALID, 16'hA001 + 16'(i)); end
      end
      drive_idle(); step();
      vectors++; if (IN_VALID !== 1'b0 || FIFO_COUNT !== 3'd0 || IN !== 16'hA004) begin
        miscompares++; $display("FAIL wrap_drained rep%0d: v=%b count=%0d IN=%h want 0 0 a004", rep, IN_VALID, FIFO_COUNT, IN); end
      clear_flags();
    end
  endtask

  task automatic test_empty_bypass();
    read_word();
    vectors++; if (IN !== 16'hA004 || IN_VALID !== 1'b0 || ERR_FLAGS !== 3'b010) begin
      miscompares++; $display("FAIL empty_read: IN=%h v=%b err=%b want a004 0 010", IN, IN_VALID, ERR_FLAGS); end
    clear_flags();
    drive_idle(); IOE = 1; IOR = 1; PORTIN = 16'hBEEF; PORTIN_VALID = 1; step();
    vectors++; if (IN !== 16'hBEEF || IN_VALID !== 1'b1 || FIFO_COUNT !== 3'd0 || ERR_FLAGS !== 3'b000) begin
      miscompares++; $display("FAIL bypass: IN=%h v=%b count=%0d err=%b want beef 1 0 000", IN, IN_VALID, FIFO_COUNT, ERR_FLAGS); end
  endtask

  task automatic test_lanes();
    drive_idle(); IOE = 1; IOW = 1; PORT_SEL = 2'd0; Result = 16'h1357; step();
    drive_idle(); IOE = 1; IOW = 1; PORT_SEL = 2'd1; Result = 16'h5A5A; step();
    vectors++; if (PORTOUT !== {16'h0000, 16'h5A5A, 16'h1357} || PORTOUT_STB !== 3'b010) begin
      miscompares++; $display("FAIL lane1_write: out=%h stb=%b want 00005a5a1357 010", PORTOUT, PORTOUT_STB); end
    drive_idle(); step();
    vectors++; if (PORTOUT_STB !== 3'b000 || PORTOUT !== {16'h0000, 16'h5A5A, 16'h1357}) begin
      miscompares++; $display("FAIL lane_strobe_drop: out=%h stb=%b want 00005a5a1357 000", PORTOUT, PORTOUT_STB); end
    drive_idle(); IOE = 1; IOW = 1; PORT_SEL = 2'd2; Result = 16'h2468; step();
    vectors++; if (PORTOUT !== {16'h2468, 16'h5A5A, 16'h1357} || PORTOUT_STB !== 3'b100) begin
      miscompares++; $display("FAIL lane2_write: out=%h stb=%b want 24685a5a1357 100", PORTOUT, PORTOUT_STB); end
    drive_idle(); IOE = 1; IOW = 1; PORT_SEL = 2'd3; Result = 16'hFFFF; step();
    vectors++; if (PORTOUT !== {16'h2468, 16'h5A5A, 16'h1357} || PORTOUT_STB !== 3'b000 || ERR_FLAGS !== 3'b100) begin
      miscompares++; $display("FAIL bad_sel: out=%h stb=%b err=%b want 24685a5a1357 000 100", PORTOUT, PORTOUT_STB, ERR_FLAGS); end
    clear_flags();
  endtask

  task automatic test_combined();
    push_word(16'h0042);
    drive_idle(); IOE = 1; IOR = 1; IOW = 1; PORT_SEL = 2'd0; Result = 16'h7777; step();
    vectors++; if (IN !== 16'h0042 || IN_VALID !== 1'b1 || PORTOUT[15:0] !== 16'h7777 || PORTOUT_STB !== 3'b001) begin
      miscompares++; $display("FAIL combined: IN=%h v=%b lane0=%h stb=%b want 0042 1 7777 001", IN, IN_VALID, PORTOUT[15:0], PORTOUT_STB); end
    push_word(16'h0099);
    drive_idle(); IOE = 0; IOR = 1; IOW = 1; PORT_SEL = 2'd1; Result = 16'h1111; step();
    vectors++; if (IN !== 16'h0042 || IN_VALID !== 1'b0 || FIFO_COUNT !== 3'd1 || PORTOUT[31:16] !== 16'h5A5A
                   || PORTOUT_STB !== 3'b000 || ERR_FLAGS !== 3'b000) begin
      miscompares++; $display("FAIL ioe_low: IN=%h v=%b count=%0d lane1=%h stb=%b err=%b want 0042 0 1 5a5a 000 000",
                              IN, IN_VALID, FIFO_COUNT, PORTOUT[31:16], PORTOUT_STB, ERR_FLAGS); end
    read_word();
    vectors++; if (IN !== 16'h0099 || FIFO_COUNT !== 3'd0) begin
      miscompares++; $display("FAIL combined_drain: IN=%h count=%0d want 0099 0", IN, FIFO_COUNT); end
  endtask

  task automatic test_flag_clear();
    read_word();
    clear_flags();
    vectors++; if (ERR_FLAGS !== 3'b000) begin
      miscompares++; $display("FAIL flag_clear: err=%b want 000", ERR_FLAGS); end
    for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
    drive_idle(); CLR_FLAGS = 1; PORTIN = 16'hC0FF; PORTIN_VALID = 1; step();
    vectors++; if (ERR_FLAGS !== 3'b001 || FIFO_COUNT !== 3'd4) begin
      miscompares++; $display("FAIL clear_vs_overflow: err=%b count=%0d want 001 4", ERR_FLAGS, FIFO_COUNT); end
    drive_idle(); IOE = 1; IOR = 1; PORTIN = 16'hC0EE; PORTIN_VALID = 1; step();
    vectors++; if (IN !== 16'hC000 || FIFO_COUNT !== 3'd3 || ERR_FLAGS !== 3'b001) begin
      miscompares++; $display("FAIL full_push_pop: IN=%h count=%0d err=%b want c000 3 001", IN, FIFO_COUNT, ERR_FLAGS); end
    for (int i = 1; i < 4; i++) begin
      read_word();
      vectors++; if (IN !== 16'hC000 + 16'(i)) begin
        miscompares++; $display("FAIL flag_drain i%0d: IN=%h want %h", i, IN, 16'hC000 + 16'(i)); end
    end
    clear_flags();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_idle();
      IOE          = ($urandom_range(0, 3) != 0);
      IOR          = ($urandom_range(0, 2) == 0);
      IOW          = ($urandom_range(0, 2) == 0);
      PORT_SEL     = 2'($urandom_range(0, 3));
      Result       = 16'($urandom);
      PORTIN       = 16'($urandom);
      PORTIN_VALID = ($urandom_range(0, 1) == 1);
      CLR_FLAGS    = ($urandom_range(0, 7) == 0);
      step();
      vectors++; if (IN !== m_in || IN_VALID !== m_inv) begin
        miscompares++; $display("FAIL rand_in n%0d: IN=%h v=%b want %h %b", n, IN, IN_VALID, m_in, m_inv); end
      vectors++; if (FIFO_COUNT !== 3'(mq.size()) || PORTIN_READY !== (mq.size() < D)) begin
        miscompares++; $display("FAIL rand_count n%0d: count=%0d rdy=%b want %0d %b", n, FIFO_COUNT, PORTIN_READY, mq.size(), mq.size() < D); end
      vectors++; if (PORTOUT !== {m_lane[2], m_lane[1], m_lane[0]} || PORTOUT_STB !== m_stb) begin
        miscompares++; $display("FAIL rand_out n%0d: out=%h stb=%b want %h %b", n, PORTOUT, PORTOUT_STB,
                                {m_lane[2], m_lane[1], m_lane[0]}, m_stb); end
      vectors++; if (ERR_FLAGS !== m_flags) begin
        miscompares++; $display("FAIL rand_flags n%0d: err=%b want %b", n, ERR_FLAGS, m_flags); end
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    #12 reset = 1;
    test_reset();
    test_fifo_wrap();
    test_empty_bypass();
    test_lanes();
    test_combined();
    test_flag_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
